// File: rtl/mul_unit_sequencer.sv
// Multi-cycle HI/LO multiply controller: radix-2 shift-add over WIDTH cycles plus a sign-fix/accumulate cycle.
// Optional macro MUL_SEQ_EARLY_OUT_EN ends the shift-add phase once the remaining multiplier bits are zero.
module mul_unit_sequencer #(
  parameter int         WIDTH     = 32,
  parameter logic [2:0] MUL_MADD  = 3'b000,
  parameter logic [2:0] MUL_MADDU = 3'b001,
  parameter logic [2:0] MUL_MUL   = 3'b010,
  parameter logic [2:0] MUL_MFHI  = 3'b101,
  parameter logic [2:0] MUL_MFLO  = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mul_op,
  input  logic             start,
  input  logic             rd_req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 CW     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ONE_C  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST_C = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [2*WIDTH-1:0] mcand_r, partial_r, prod_s, hilo_nx_s;
  logic [WIDTH-1:0]   mplier_r, hi_r, lo_r, mag_a_s, mag_b_s;
  logic [CW-1:0]      count_r;
  logic               neg_r, accum_r, busy_r, done_r;
  logic               accept_s, signed_op_s, last_iter_s;

  // Start acceptance decode and operand magnitudes for signed ops
  always_comb begin
    accept_s    = 1'b0;
    signed_op_s = 1'b0;
    if (start && (state_r == ST_IDLE)) begin
      case (mul_op)
        MUL_MADD, MUL_MUL: begin
          accept_s    = 1'b1;
          signed_op_s = 1'b1;
        end
        MUL_MADDU: accept_s = 1'b1;
        default:   accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
    // the most-negative value maps onto itself, which reads correctly as an unsigned magnitude
    mag_a_s = (signed_op_s && op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
    mag_b_s = (signed_op_s && op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;
  end

  // Iteration termination and the sign-corrected / accumulated result
  always_comb begin
`ifdef MUL_SEQ_EARLY_OUT_EN
    last_iter_s = (count_r == LAST_C) || (mplier_r[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
    last_iter_s = (count_r == LAST_C);
`endif
    prod_s    = neg_r ? (~partial_r + ONE_P) : partial_r;
    hilo_nx_s = accum_r ? ({hi_r, lo_r} + prod_s) : prod_s;
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_iter_s) begin
          state_nx_s = ST_FIX;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_FIX:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand latch, shift-add datapath, HI/LO update and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r   <= {(2*WIDTH){1'b0}};
      partial_r <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      neg_r     <= 1'b0;
      accum_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s != ST_IDLE);
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            mcand_r   <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r  <= mag_b_s;
            partial_r <= {(2*WIDTH){1'b0}};
            count_r   <= {CW{1'b0}};
            neg_r     <= signed_op_s & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            accum_r   <= (mul_op != MUL_MUL);
          end
        end
        ST_RUN: begin
          if (mplier_r[0]) begin
            partial_r <= partial_r + mcand_r;
          end
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + ONE_C;
        end
        ST_FIX: begin
          {hi_r, lo_r} <= hilo_nx_s;
          done_r       <= 1'b1;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign hi      = hi_r;
  assign lo      = lo_r;
  assign stall   = busy_r & (start | rd_req);
  assign rd_data = (mul_op == MUL_MFHI) ? hi_r : lo_r;

endmodule

// File: tb/tb_mul_unit_sequencer.sv
// Self-checking bench for mul_unit_sequencer: directed scenarios plus random ops against a 64-bit arithmetic model.
module tb_mul_unit_sequencer;

  localparam int         W        = 32;
  localparam logic [2:0] OP_MADD  = 3'b000;
  localparam logic [2:0] OP_MADDU = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_MFLO  = 3'b100;
  localparam logic [2:0] OP_MFHI  = 3'b101;

  logic         clk = 1'b0;
  logic         rst, start, rd_req;
  logic [2:0]   mul_op;
  logic [W-1:0] op_a, op_b, rd_data, hi, lo;
  logic         busy, done, stall;

  int           checks = 0;
  int           errors = 0;
  logic [63:0]  model_hl = 64'd0;
  int           k, cyc, dcount;

  always #5 clk = ~clk;

  mul_unit_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mul_op(mul_op), .start(start), .rd_req(rd_req),
    .op_a(op_a), .op_b(op_b), .rd_data(rd_data), .busy(busy), .done(done),
    .stall(stall), .hi(hi), .lo(lo)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (op == OP_MADDU) return {32'd0, a} * {32'd0, b};
    return sa * sb;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
    logic [31:0] m;
    int top;
    m   = (op != OP_MADDU && b[31]) ? (32'd0 - b) : b;
    top = 0;
    for (int i = 0; i < 32; i++) if (m[i]) top = i;
`ifdef MUL_SEQ_EARLY_OUT_EN
    return top + 2;
`else
    return W + 1 + (top - top);
`endif
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mul_op = op; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; mul_op = OP_MFLO;
    @(negedge clk);
    check_val("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) break;
      check_val("busy_in_flight", 64'(busy), 64'd1);
    end
    if (!done) check_val("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] p;
    p = ref_product(op, a, b);
    model_hl = (op == OP_MUL) ? p : model_hl + p;
    launch(op, a, b);
    wait_done(n);
    check_val("latency", 64'(n), 64'(exp_lat(op, b)));
    check_val("busy_at_done", 64'(busy), 64'd0);
    check_val("hi", 64'(hi), 64'(model_hl[63:32]));
    check_val("lo", 64'(lo), 64'(model_hl[31:0]));
    @(negedge clk);
    check_val("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corners [4];
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    corners = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
    rst = 1'b1; start = 1'b0; rd_req = 1'b0; mul_op = OP_MFLO; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset_hi", 64'(hi), 64'd0);
    check_val("reset_lo", 64'(lo), 64'd0);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    check_val("reset_stall", 64'(stall), 64'd0);

    // MUL 7 * -3, then read back through MFLO/MFHI
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    check_val("mul7_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    rd_req = 1'b1; mul_op = OP_MFLO; #1;
    check_val("mflo_data", 64'(rd_data), 64'hFFFF_FFEB);
    check_val("mflo_stall", 64'(stall), 64'd0);
    mul_op = OP_MFHI; #1;
    check_val("mfhi_data", 64'(rd_data), 64'hFFFF_FFFF);
    rd_req = 1'b0; mul_op = OP_MFLO;

    run_op(OP_MUL, 32'd5, 32'd1);
    run_op(OP_MADDU, 32'hFFFF_FFFF, 32'd2);
    check_val("maddu_hilo", {hi, lo}, 64'h0000_0002_0000_0003);
    run_op(OP_MUL, 32'd0, 32'd0);
    run_op(OP_MADD, 32'h8000_0000, 32'h8000_0000);
    check_val("madd_minneg", {hi, lo}, 64'h4000_0000_0000_0000);
    run_op(OP_MADD, 32'hFFFF_FFFF, 32'd1);
    check_val("madd_neg1", {hi, lo}, 64'h3FFF_FFFF_FFFF_FFFF);
    run_op(OP_MUL, 32'd9, 32'd1);
    check_val("mul9_lo", 64'(lo), 64'd9);

    // starts with non-multiply opcodes are ignored
    for (int i = 0; i < 2; i++) begin
      start = 1'b1; mul_op = (i == 0) ? 3'b011 : OP_MFLO; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1 start = 1'b0; mul_op = OP_MFLO;
      @(negedge clk);
      check_val("ignored_busy", 64'(busy), 64'd0);
      check_val("ignored_hilo", {hi, lo}, model_hl);
    end

    // read and start in the same idle cycle: read sees the pre-multiply LO
    rd_req = 1'b1; start = 1'b1; mul_op = OP_MUL; op_a = 32'd3; op_b = 32'd4; #1;
    check_val("rd_start_data", 64'(rd_data), 64'(model_hl[31:0]));
    check_val("rd_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1 start = 1'b0; rd_req = 1'b0; mul_op = OP_MFLO;
    model_hl = 64'd12;
    @(negedge clk);
    check_val("rd_start_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check_val("rd_start_lo", {hi, lo}, model_hl);

    // read request arriving mid-multiply stalls until the done cycle
    launch(OP_MUL, 32'd11, 32'h0001_2345);
    model_hl = ref_product(OP_MUL, 32'd11, 32'h0001_2345);
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1; k++;
      if (k == 5) begin rd_req = 1'b1; mul_op = OP_MFLO; end
      @(negedge clk);
      if (done) break;
      check_val("stall_rd", 64'(stall), 64'(rd_req));
    end
    check_val("rd_latency", 64'(k), 64'(exp_lat(OP_MUL, 32'h0001_2345)));
    check_val("rd_stall_done", 64'(stall), 64'd0);
    check_val("rd_data_done", 64'(rd_data), 64'(model_hl[31:0]));
    rd_req = 1'b0;

    // start held during busy is accepted in the done cycle
    launch(OP_MUL, 32'd100, 32'd200);
    model_hl = 64'd20000;
    k = 0;
    while (k < 100) begin
      @(posedge clk); #1; k++;
      if (k == 3) begin start = 1'b1; mul_op = OP_MADDU; op_a = 32'd1000; op_b = 32'd3; end
      @(negedge clk);
      if (done) break;
      check_val("stall_start", 64'(stall), (k >= 3) ? 64'd1 : 64'd0);
    end
    check_val("held_stall_done", 64'(stall), 64'd0);
    check_val("held_first_lo", {hi, lo}, model_hl);
    model_hl = model_hl + 64'd3000;
    @(posedge clk); #1 start = 1'b0; mul_op = OP_MFLO;
    @(negedge clk);
    check_val("held_accepted_busy", 64'(busy), 64'd1);
    check_val("held_accepted_done", 64'(done), 64'd0);
    wait_done(cyc);
    check_val("held_latency", 64'(cyc), 64'(exp_lat(OP_MADDU, 32'd3)));
    check_val("held_second_hilo", {hi, lo}, model_hl);

    // synchronous reset in the middle of RUN discards the result
    @(negedge clk);
    launch(OP_MUL, 32'h1234_5678, 32'h8000_0001);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    model_hl = 64'd0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_hilo", {hi, lo}, 64'd0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check_val("abort_no_done", 64'(dcount), 64'd0);

    // randomized operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(2))
        0:       rop = OP_MUL;
        1:       rop = OP_MADD;
        default: rop = OP_MADDU;
      endcase
      ra = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : $urandom;
      rb = ($urandom_range(3) == 0) ? corners[$urandom_range(3)] : $urandom;
      if ($urandom_range(3) == 0) rb = rb >> $urandom_range(31);
      run_op(rop, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
